// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an 8N1 serializer.
// The CPU polls _flag_do (low = room available) before writing; a write into a
// full FIFO is dropped and latches the sticky overflow flag.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     _mr,
  input  logic                     _wr,
  input  logic [7:0]               data,
  output logic                     _flag_do,
  output logic                     txd,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [BW-1:0] CLK_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [1:0]            state;
  logic [BW-1:0]         clk_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;

  logic full, empty, wr_ok, wr_drop, bit_end, pop;

  // Full/empty and the write decision all use the pre-edge count, so a pop on
  // the same edge never makes room for a write, and a fresh byte is never
  // popped on the edge that writes it.
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wr_ok    = !_wr && !full;
  assign wr_drop  = !_wr && full;
  assign bit_end  = (clk_cnt == CLK_LAST);
  assign pop      = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
  assign _flag_do = full;
  assign busy     = (state != S_IDLE);

  // Storage: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_drop) overflow <= 1'b1;
    end
  end

  // Serializer: txd is loaded together with the state change so it is a
  // clean register output; STOP chains straight into START when data waits.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state   <= S_IDLE;
      txd     <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            clk_cnt <= '0;
            bit_idx <= '0;
            txd     <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            txd     <= shreg[0];
            state   <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + BW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              txd   <= 1'b0;
              state <= S_START;
            end else begin
              txd   <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + BW'(1);
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DEPTH=4, CLKS_PER_BIT=4.
module tb_uart_tx_fifo;

  logic       clk;
  logic       _mr;
  logic       _wr;
  logic [7:0] data;
  logic       _flag_do;
  logic       txd;
  logic       busy;
  logic [2:0] count;
  logic       overflow;

  int vectors;
  int miscompares;

  logic       mon_en;
  logic [8:0] rx_q[$];

  uart_tx_fifo #(.DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), ._mr(_mr), ._wr(_wr), .data(data), ._flag_do(_flag_do),
    .txd(txd), .busy(busy), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial receiver, sampling mid-bit on falling edges; stores {stop, byte}.
  always begin
    @(negedge clk);
    if (mon_en && txd === 1'b0) begin
      logic [7:0] b;
      b = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = txd;
      end
      repeat (4) @(negedge clk);
      rx_q.push_back({txd, b});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check txd over frame positions start..39; position 0 is the cycle right
  // after the start bit begins.
  task automatic check_frame(input logic [7:0] b, input int start);
    for (int k = start; k < 40; k++) begin
      logic e;
      int   bit_no;
      bit_no = k / 4;
      if (bit_no == 0)      e = 1'b0;
      else if (bit_no == 9) e = 1'b1;
      else                  e = b[bit_no - 1];
      chk($sformatf("frame_%02h_pos%0d", b, k), {31'd0, txd}, {31'd0, e});
      step();
    end
  endtask

  initial begin
    int t;
    int lows;
    int max_cnt;
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    _mr  = 1'b0;
    _wr  = 1'b1;
    data = 8'h00;

    // Reset
    repeat (3) step();
    chk("rst_txd",  {31'd0, txd},      32'd1);
    chk("rst_busy", {31'd0, busy},     32'd0);
    chk("rst_cnt",  {29'd0, count},    32'd0);
    chk("rst_flag", {31'd0, _flag_do}, 32'd0);
    chk("rst_ovf",  {31'd0, overflow}, 32'd0);
    _mr = 1'b1;
    step();
    chk("rel_txd",  {31'd0, txd},      32'd1);
    chk("rel_cnt",  {29'd0, count},    32'd0);
    chk("rel_busy", {31'd0, busy},     32'd0);

    // Single byte 0xA5
    data = 8'hA5; _wr = 1'b0;
    step();
    _wr = 1'b1;
    chk("one_cnt1", {29'd0, count}, 32'd1);
    chk("one_txd_hi", {31'd0, txd}, 32'd1);
    step();
    chk("one_pop_cnt", {29'd0, count}, 32'd0);
    chk("one_busy", {31'd0, busy}, 32'd1);
    check_frame(8'hA5, 0);
    chk("one_end_busy", {31'd0, busy}, 32'd0);
    chk("one_end_txd", {31'd0, txd}, 32'd1);
    chk("one_end_cnt", {29'd0, count}, 32'd0);

    // Back-to-back 0x01,0x02,0x03
    data = 8'h01; _wr = 1'b0;
    step();
    chk("b2b_cnt_a", {29'd0, count}, 32'd1);
    data = 8'h02;
    step();
    chk("b2b_cnt_b", {29'd0, count}, 32'd1);
    chk("b2b_start", {31'd0, txd}, 32'd0);
    data = 8'h03;
    step();
    _wr = 1'b1;
    chk("b2b_cnt_c", {29'd0, count}, 32'd2);
    check_frame(8'h01, 1);
    check_frame(8'h02, 0);
    check_frame(8'h03, 0);
    chk("b2b_end_busy", {31'd0, busy}, 32'd0);
    chk("b2b_end_cnt", {29'd0, count}, 32'd0);

    // Overflow: 0x0F starts a frame, then 0x10..0x14 on consecutive edges
    data = 8'h0F; _wr = 1'b0;
    step();
    _wr = 1'b1;
    step();
    chk("ovf_pop_cnt", {29'd0, count}, 32'd0);
    for (int j = 0; j < 5; j++) begin
      data = 8'h10 + 8'(j); _wr = 1'b0;
      step();
      if (j < 4) chk($sformatf("ovf_cnt%0d", j), {29'd0, count}, 32'(j + 1));
      if (j == 3) begin
        chk("ovf_flag_full", {31'd0, _flag_do}, 32'd1);
        chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
      end
    end
    _wr = 1'b1;
    chk("ovf_cnt_hold", {29'd0, count}, 32'd4);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    check_frame(8'h0F, 5);
    chk("ovf_after_pop_cnt", {29'd0, count}, 32'd3);
    chk("ovf_after_pop_flag", {31'd0, _flag_do}, 32'd0);
    check_frame(8'h10, 0);
    check_frame(8'h11, 0);
    check_frame(8'h12, 0);
    check_frame(8'h13, 0);
    chk("ovf_end_busy", {31'd0, busy}, 32'd0);
    chk("ovf_end_cnt", {29'd0, count}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset pulse clears overflow
    _mr = 1'b0;
    #2;
    chk("mr_clr_ovf", {31'd0, overflow}, 32'd0);
    step();
    _mr = 1'b1;
    step();

    // Pointer wrap: stream 0x00..0x09, writing whenever _flag_do is low
    rx_q.delete();
    mon_en  = 1'b1;
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      t = 0;
      _wr = 1'b1;
      while (_flag_do && t < 200) begin
        step();
        if (int'(count) > max_cnt) max_cnt = int'(count);
        t++;
      end
      chk($sformatf("wrap_wait%0d", i), {31'd0, (t >= 200)}, 32'd0);
      data = 8'(i); _wr = 1'b0;
      step();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    _wr = 1'b1;
    t = 0;
    while (rx_q.size() < 10 && t < 1000) begin
      step();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      t++;
    end
    chk("wrap_rx_n", rx_q.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < rx_q.size())
        chk($sformatf("wrap_rx%0d", i), {23'd0, rx_q[i]}, {23'd0, 1'b1, 8'(i)});
    end
    chk("wrap_max_cnt", max_cnt, 32'd4);
    chk("wrap_no_ovf", {31'd0, overflow}, 32'd0);
    mon_en = 1'b0;
    repeat (4) step();

    // Reset during data bit 3 of 0x5A with 2 bytes queued
    data = 8'h5A; _wr = 1'b0;
    step();
    data = 8'h11;
    step();
    data = 8'h22;
    step();
    _wr = 1'b1;
    chk("mid_cnt2", {29'd0, count}, 32'd2);
    repeat (16) step();
    chk("mid_bit3", {31'd0, txd}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #3 _mr = 1'b0;
    #1;
    chk("mid_rst_txd", {31'd0, txd}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cnt", {29'd0, count}, 32'd0);
    #1 _mr = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("mid_quiet", lows, 32'd0);
    chk("mid_quiet_cnt", {29'd0, count}, 32'd0);
    data = 8'h3C; _wr = 1'b0;
    step();
    _wr = 1'b1;
    step();
    check_frame(8'h3C, 0);
    chk("mid_new_end_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
